// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting-round controller.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    EVAL   = 2'd2,
    RESULT = 2'd3
  } vote_state_t;

  // Smallest YES count that wins for an odd number of voters
  function automatic int unsigned maj_thresh(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational YES-vote counter over the frozen snapshot.
module vote_popcount #(
  parameter int unsigned NVOTERS = 5
) (
  input  logic [NVOTERS-1:0]           votes,
  output logic [$clog2(NVOTERS+1)-1:0] yes_cnt_c
);

  localparam int unsigned CW = $clog2(NVOTERS + 1);

  always_comb begin
    yes_cnt_c = '0;
    for (int i = 0; i < int'(NVOTERS); i++) begin
      yes_cnt_c = yes_cnt_c + CW'(votes[i]);
    end
  end

endmodule

// File: rtl/vote_round_ctrl.sv
// Sequences one voting round: sync inputs, timed window, snapshot, verdict display.
// Optional VOTE_ROUND_STATS_EN adds saturating pass/fail round counters.
module vote_round_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned NVOTERS     = 5,
  parameter int unsigned OPEN_CYCLES = 100000000,
  parameter int unsigned HOLD_CYCLES = 200000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NVOTERS-1:0]           sw,
  input  logic                         btn_start,
  input  logic                         btn_close,
  output logic                         led_open,
  output logic                         led_valid,
  output logic                         led_result,
  output logic [$clog2(NVOTERS+1)-1:0] vote_count,
  output logic [1:0]                   state
`ifdef VOTE_ROUND_STATS_EN
  ,
  output logic [7:0]                   pass_cnt,
  output logic [7:0]                   fail_cnt
`endif
);

  localparam int unsigned CW   = $clog2(NVOTERS + 1);
  localparam int unsigned TMAX = max_u(OPEN_CYCLES, HOLD_CYCLES);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [NVOTERS-1:0] sw_s1, sw_s2;
  logic [1:0]         btn_s1, btn_s2, btn_d;
  logic               start_p_c, close_p_c;

  vote_state_t        st;
  logic [TW-1:0]      timer;
  logic [NVOTERS-1:0] snapshot;
  logic [CW-1:0]      yes_cnt_c;
  logic               verdict_c;

  // Two-flop synchronisers plus one delay stage for button edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_d  <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= {btn_close, btn_start};
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign start_p_c = btn_s2[0] & ~btn_d[0];
  assign close_p_c = btn_s2[1] & ~btn_d[1];

  vote_popcount #(.NVOTERS(NVOTERS)) u_popcount (
    .votes     (snapshot),
    .yes_cnt_c (yes_cnt_c)
  );

  assign verdict_c = (yes_cnt_c >= CW'(maj_thresh(NVOTERS)));
  assign state     = st;

  // Round FSM; LED flags are updated on the same edge as the state they mirror
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      timer      <= '0;
      snapshot   <= '0;
      vote_count <= '0;
      led_result <= 1'b0;
      led_open   <= 1'b0;
      led_valid  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start_p_c) begin
            st       <= OPEN;
            timer    <= TW'(OPEN_CYCLES - 1);
            led_open <= 1'b1;
          end
        end
        OPEN: begin
          if (close_p_c || (timer == '0)) begin
            st       <= EVAL;
            snapshot <= sw_s2;
            led_open <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        EVAL: begin
          st         <= RESULT;
          vote_count <= yes_cnt_c;
          led_result <= verdict_c;
          timer      <= TW'(HOLD_CYCLES - 1);
          led_valid  <= 1'b1;
        end
        RESULT: begin
          if (start_p_c) begin
            st        <= OPEN;
            timer     <= TW'(OPEN_CYCLES - 1);
            led_valid <= 1'b0;
            led_open  <= 1'b1;
          end else if (timer == '0) begin
            st        <= IDLE;
            led_valid <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          st        <= IDLE;
          led_open  <= 1'b0;
          led_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef VOTE_ROUND_STATS_EN
  // One count per evaluated round, saturating at 255
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (st == EVAL) begin
      if (verdict_c) begin
        if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
      end else begin
        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Scoreboard bench for vote_round_ctrl (NVOTERS=5, OPEN_CYCLES=20, HOLD_CYCLES=10).
module tb_vote_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sw = '0;
  logic       btn_start = 1'b0;
  logic       btn_close = 1'b0;
  logic       led_open, led_valid, led_result;
  logic [2:0] vote_count;
  logic [1:0] state;
`ifdef VOTE_ROUND_STATS_EN
  logic [7:0] pass_cnt, fail_cnt;
`endif

  vote_round_ctrl #(
    .NVOTERS     (5),
    .OPEN_CYCLES (20),
    .HOLD_CYCLES (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn_start  (btn_start),
    .btn_close  (btn_close),
    .led_open   (led_open),
    .led_valid  (led_valid),
    .led_result (led_result),
    .vote_count (vote_count),
    .state      (state)
`ifdef VOTE_ROUND_STATS_EN
    ,
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] cnt;
    logic       res;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Verdict comparison whenever a new RESULT display begins
  always @(negedge clk) begin
    if (led_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'(1), 32'(0));
      end else begin
        sb_e = sb.pop_front();
        check("sb_vote_count", 32'(vote_count), 32'(sb_e.cnt));
        check("sb_led_result", 32'(led_result), 32'(sb_e.res));
      end
    end
    prev_valid = led_valid;
  end

  task automatic press_start(input bit lat, input bit push, input logic [2:0] c, input logic r);
    exp_t e;
    if (push) begin
      e.cnt = c;
      e.res = r;
      sb.push_back(e);
    end
    btn_start = 1'b1;
    repeat (2) @(negedge clk);
    if (lat) check("start_latency_not_yet", 32'(state), 32'(0));
    @(negedge clk);
    if (lat) begin
      check("start_state_open", 32'(state), 32'(1));
      check("start_led_open", 32'(led_open), 32'(1));
    end
    btn_start = 1'b0;
  endtask

  task automatic measure(input logic [1:0] s, output int n);
    n = 0;
    while (state == s && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Counts OPEN cycles from the current (first) one; optionally presses close at cycle close_at
  task automatic run_open(input int close_at, output int len);
    len = 0;
    while (state == 2'd1 && len < 1000) begin
      len++;
      if (len == close_at) btn_close = 1'b1;
      @(negedge clk);
    end
    btn_close = 1'b0;
  endtask

  int n, len;
  int stats_before;

  initial begin
    stats_before = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state), 32'(0));
    check("rst_led_open", 32'(led_open), 32'(0));
    check("rst_led_valid", 32'(led_valid), 32'(0));
    check("rst_led_result", 32'(led_result), 32'(0));
    check("rst_vote_count", 32'(vote_count), 32'(0));
`ifdef VOTE_ROUND_STATS_EN
    check("rst_pass_cnt", 32'(pass_cnt), 32'(0));
    check("rst_fail_cnt", 32'(fail_cnt), 32'(0));
`endif

    // Close outside OPEN does nothing
    btn_close = 1'b1;
    repeat (5) @(negedge clk);
    check("close_in_idle", 32'(state), 32'(0));
    btn_close = 1'b0;
    repeat (3) @(negedge clk);

    // Full-length round, 3 of 5 YES
    sw = 5'b10110;
    press_start(1, 1, 3'd3, 1'b1);
    run_open(0, len);
    check("a_open_len", 32'(len), 32'(20));
    check("a_eval_led_open", 32'(led_open), 32'(0));
    check("a_eval_led_valid", 32'(led_valid), 32'(0));
    measure(2'd2, n);
    check("a_eval_len", 32'(n), 32'(1));
    check("a_led_valid", 32'(led_valid), 32'(1));
    measure(2'd3, n);
    check("a_result_len", 32'(n), 32'(10));
    check("a_back_idle", 32'(state), 32'(0));
    check("a_idle_led_valid", 32'(led_valid), 32'(0));

    // Early close at OPEN cycle 5, 2 of 5 YES; switch changes after snapshot ignored
    sw = 5'b00011;
    press_start(0, 1, 3'd2, 1'b0);
    run_open(3, len);
    check("b_open_len", 32'(len), 32'(5));
    measure(2'd2, n);
    check("b_eval_len", 32'(n), 32'(1));
    sw = 5'b11111;
    repeat (5) @(negedge clk);
    check("b_frozen_count", 32'(vote_count), 32'(2));
    check("b_frozen_result", 32'(led_result), 32'(0));
    measure(2'd3, n);
    check("b_back_idle", 32'(state), 32'(0));

    // Close pulse lands on the timeout edge: one EVAL only
    sw = 5'b11100;
`ifdef VOTE_ROUND_STATS_EN
    stats_before = int'(pass_cnt) + int'(fail_cnt);
`endif
    press_start(0, 1, 3'd3, 1'b1);
    run_open(18, len);
    check("c_open_len", 32'(len), 32'(20));
    measure(2'd2, n);
    check("c_eval_len", 32'(n), 32'(1));
`ifdef VOTE_ROUND_STATS_EN
    check("c_stats_delta", 32'(int'(pass_cnt) + int'(fail_cnt)), 32'(stats_before + 1));
`endif
    measure(2'd3, n);
    check("c_result_len", 32'(n), 32'(10));

    // Start during RESULT restarts immediately; held/re-pressed start in OPEN is ignored
    sw = 5'b00001;
    press_start(0, 1, 3'd1, 1'b0);
    run_open(0, len);
    measure(2'd2, n);
    @(negedge clk);
    sw = 5'b01111;
    press_start(0, 1, 3'd4, 1'b1);
    check("d_restart_state", 32'(state), 32'(1));
    check("d_restart_led_valid", 32'(led_valid), 32'(0));
    check("d_restart_keep_count", 32'(vote_count), 32'(1));
    btn_start = 1'b1;
    fork
      begin
        repeat (2) @(negedge clk);
        btn_start = 1'b0;
        repeat (2) @(negedge clk);
        btn_start = 1'b1;
        repeat (46) @(negedge clk);
        btn_start = 1'b0;
      end
      begin
        run_open(0, len);
        check("d_open_len_held", 32'(len), 32'(20));
        measure(2'd2, n);
        check("d_eval_len", 32'(n), 32'(1));
        measure(2'd3, n);
        check("d_result_len", 32'(n), 32'(10));
      end
    join
    check("d_no_restart_idle", 32'(state), 32'(0));
    repeat (4) @(negedge clk);

    // Reset mid-round discards everything
    sw = 5'b11111;
    press_start(0, 0, 3'd0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("e_rst_state", 32'(state), 32'(0));
    check("e_rst_led_open", 32'(led_open), 32'(0));
    check("e_rst_led_valid", 32'(led_valid), 32'(0));
    check("e_rst_led_result", 32'(led_result), 32'(0));
    check("e_rst_vote_count", 32'(vote_count), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

`ifdef VOTE_ROUND_STATS_EN
    // Saturation of the pass counter
    sw = 5'b11111;
    for (int i = 0; i < 260; i++) begin
      press_start(0, 1, 3'd5, 1'b1);
      measure(2'd1, n);
      measure(2'd2, n);
      measure(2'd3, n);
    end
    check("f_pass_sat", 32'(pass_cnt), 32'(255));
    check("f_fail_zero", 32'(fail_cnt), 32'(0));
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
